cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter TAG_W SHALL be: TAG_W, 4, width of requester tag carried through to the response.
REQ-002 Port clk SHALL be: clk  input  1  sole clock, all state on rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Ports for requester n (n=0,1) SHALL be: reqn_valid input 1 request present; reqn_ready output 1 request accepted this cycle; reqn_op input comparator::op_t comparison select; reqn_a input `XLEN operand a; reqn_b input `XLEN operand b; reqn_tag input TAG_W requester tag.
REQ-005 Response ports SHALL be: rsp_valid output 1 result held; rsp_ready input 1 consumer takes result; rsp_src output 1 granted requester index; rsp_tag output TAG_W tag of granted request; rsp_result output 1 comparison outcome.

Function
REQ-006 Block SHALL share one Comparator instance between two requesters; op/a/b of the granted request SHALL drive it.
REQ-007 Handshake: a transfer on a port SHALL occur when valid and ready are both high at a rising edge.
REQ-008 Output stage SHALL be a two-state machine, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-009 Accept condition SHALL be: state EMPTY, or state FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-010 At most one reqn_ready SHALL be high per cycle; reqn_ready SHALL be high only for the granted requester when the accept condition holds and reqn_valid=1.
REQ-011 On accept, rsp_result/rsp_src/rsp_tag SHALL register the comparator output, grant index, and tag; latency request-to-rsp_valid SHALL be exactly 1 cycle.
REQ-012 Transitions: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL on rsp_ready with accept or on rsp_ready=0.
REQ-013 While FULL and rsp_ready=0, rsp_* SHALL hold stable and both reqn_ready SHALL be 0.
REQ-014 Only one requester valid: that requester SHALL be granted regardless of arbitration state.
REQ-015 reqn_ready SHALL depend combinationally on reqn_valid and rsp_ready; it SHALL NOT depend on reqn_op/a/b.
REQ-016 op TRUE SHALL produce rsp_result=1; undefined op encodings are illegal and SHALL NOT be issued by requesters.

Reset
REQ-017 With reset high at a clock edge: state SHALL go to EMPTY, rsp_valid=0, rsp_result=0, rsp_src=0, rsp_tag=0, last-grant pointer=1 (so requester 0 wins the first tie).
REQ-018 Reset mid-operation SHALL discard any held result without a response; both reqn_ready SHALL be 0 while reset is high.

Configuration
REQ-019 Macro CMP_ARB_ROUND_ROBIN_EN defined: on a tie (both valid), the requester not granted last SHALL win; the pointer SHALL update only on an accept.
REQ-020 Macro CMP_ARB_ROUND_ROBIN_EN undefined: on a tie, requester 0 SHALL always win (fixed priority); no pointer flop is built.

Structure
REQ-021 comparator::op_t and `XLEN SHALL come from the existing shared package/include; no new package types are required.
REQ-022 Grant logic SHALL be a sub-module cmp_arb_grant (inputs: valid pair, last-grant pointer; output: one-hot grant); the Comparator SHALL be instantiated once.

Verification
REQ-023 Req0 alone, op=LT, a=32'hFFFF_FFFF, b=1, tag=3, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=1, rsp_src=0, rsp_tag=3.
REQ-024 Req1 alone, op=LTU, same operands, tag=5 -> rsp_result=0, rsp_src=1, rsp_tag=5, one cycle later.
REQ-025 Both valid for 4 consecutive accepts, rsp_ready=1 -> grants 0,1,0,1 with CMP_ARB_ROUND_ROBIN_EN; 0,0,0,0 without it.
REQ-026 Result FULL, rsp_ready=0 for 3 cycles, both requesters valid -> both ready=0, rsp_* unchanged; rsp_ready=1 -> new result next cycle, no bubble.
REQ-027 Reset asserted one cycle after an accept (op=EQ, a=b=7) -> rsp_valid=0, no response delivered; after reset, first tie grants requester 0.

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// Local types and constants for the two-requester comparator arbiter.
package cmp_arbiter_pkg;

  localparam int unsigned NumReq = 2;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

endpackage

// File: rtl/comparator.sv
// Shared comparator operation encodings used by every comparator client.
package comparator;

  typedef enum logic [2:0] {
    OpEq   = 3'd0,
    OpNe   = 3'd1,
    OpLt   = 3'd2,
    OpGe   = 3'd3,
    OpLtu  = 3'd4,
    OpGeu  = 3'd5,
    OpTrue = 3'd6
  } op_t;

endpackage

// File: rtl/cmp_arb_grant.sv
// Two-way grant: a lone requester always wins; on a tie the one not granted last wins.
module cmp_arb_grant
  import cmp_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] valid_i,
  input  logic              last_i,
  output logic [NumReq-1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i[0] && valid_i[1]) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cmp_comparator.sv
// Single-cycle combinational comparator over XLEN-wide operands.
`ifndef XLEN
`define XLEN 32
`endif

module cmp_comparator
  import comparator::*;
(
  input  op_t              op_i,
  input  logic [`XLEN-1:0] a_i,
  input  logic [`XLEN-1:0] b_i,
  output logic             result_o
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;

  always_comb begin
    result_o = 1'b0;
    unique case (op_i)
      OpEq:    result_o = (a_i == b_i);
      OpNe:    result_o = (a_i != b_i);
      OpLt:    result_o = lt_s;
      OpGe:    result_o = ~lt_s;
      OpLtu:   result_o = lt_u;
      OpGeu:   result_o = ~lt_u;
      OpTrue:  result_o = 1'b1;
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Arbitrates two requesters onto one shared comparator with a one-entry result stage.
// CMP_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise requester 0 has priority.
`ifndef XLEN
`define XLEN 32
`endif

module cmp_arbiter
  import cmp_arbiter_pkg::*;
  import comparator::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  op_t              req0_op,
  input  logic [`XLEN-1:0] req0_a,
  input  logic [`XLEN-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  op_t              req1_op,
  input  logic [`XLEN-1:0] req1_a,
  input  logic [`XLEN-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_result
);

  out_state_e       state_q;
  logic             result_q;
  logic             src_q;
  logic [TAG_W-1:0] tag_q;

  logic [NumReq-1:0] grant;
  logic              last_grant;
  logic              accept_ok;
  logic              xfer;
  op_t               sel_op;
  logic [`XLEN-1:0]  sel_a;
  logic [`XLEN-1:0]  sel_b;
  logic [TAG_W-1:0]  sel_tag;
  logic              cmp_result;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  logic last_grant_q;
  assign last_grant = last_grant_q;
`else
  // Pointer pinned to requester 1 makes every tie resolve to requester 0.
  assign last_grant = 1'b1;
`endif

  cmp_arb_grant u_grant (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_grant),
    .grant_o (grant)
  );

  assign accept_ok  = ~reset & ((state_q == StEmpty) | rsp_ready);
  assign req0_ready = accept_ok & grant[0];
  assign req1_ready = accept_ok & grant[1];
  assign xfer       = req0_ready | req1_ready;

  assign sel_op  = grant[1] ? req1_op  : req0_op;
  assign sel_a   = grant[1] ? req1_a   : req0_a;
  assign sel_b   = grant[1] ? req1_b   : req0_b;
  assign sel_tag = grant[1] ? req1_tag : req0_tag;

  cmp_comparator u_comparator (
    .op_i     (sel_op),
    .a_i      (sel_a),
    .b_i      (sel_b),
    .result_o (cmp_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEmpty;
      result_q     <= 1'b0;
      src_q        <= 1'b0;
      tag_q        <= '0;
`ifdef CMP_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else if (xfer) begin
      state_q      <= StFull;
      result_q     <= cmp_result;
      src_q        <= grant[1];
      tag_q        <= sel_tag;
`ifdef CMP_ARB_ROUND_ROBIN_EN
      last_grant_q <= grant[1];
`endif
    end else if (state_q == StFull && rsp_ready) begin
      state_q <= StEmpty;
    end
  end

  assign rsp_valid  = (state_q == StFull);
  assign rsp_result = result_q;
  assign rsp_src    = src_q;
  assign rsp_tag    = tag_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed plus random bench for cmp_arbiter with a scoreboard of expected responses.
`ifndef XLEN
`define XLEN 32
`endif

module tb_cmp_arbiter;
  import comparator::*;

  typedef struct packed {
    logic       src;
    logic [3:0] tag;
    logic       result;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  op_t              req0_op, req1_op;
  logic [`XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready, rsp_src, rsp_result;
  logic [3:0]       rsp_tag;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   m_full;
  bit   m_ptr;

  cmp_arbiter #(.TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_tag   (req1_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_src    (rsp_src),
    .rsp_tag    (rsp_tag),
    .rsp_result (rsp_result)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cmp(input op_t op, input logic [`XLEN-1:0] a,
                                 input logic [`XLEN-1:0] b);
    logic slt;
    slt = (a[`XLEN-1] ^ b[`XLEN-1]) ? a[`XLEN-1] : (a < b);
    case (op)
      OpEq:    return a == b;
      OpNe:    return a != b;
      OpLt:    return slt;
      OpGe:    return !slt;
      OpLtu:   return a < b;
      OpGeu:   return a >= b;
      OpTrue:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] m_grant(input logic v0, input logic v1, input bit ptr);
    if (v0 && v1) return ptr ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  // One clock: pre-edge ready/drain checks and model update, then post-edge output checks.
  task automatic cycle();
    logic [1:0] g;
    bit         acc;
    bit         was_reset;
    exp_t       e;
    #1;
    acc = !reset && (!m_full || rsp_ready);
    g   = m_grant(req0_valid, req1_valid, m_ptr);
    check("req0_ready", 64'(req0_ready), 64'(acc & g[0]));
    check("req1_ready", 64'(req1_ready), 64'(acc & g[1]));
    was_reset = reset;
    if (reset) begin
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 1'b1;
    end else begin
      if (m_full && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("drain_src", 64'(rsp_src), 64'(e.src));
        check("drain_tag", 64'(rsp_tag), 64'(e.tag));
        check("drain_result", 64'(rsp_result), 64'(e.result));
        m_full = 1'b0;
      end
      if (acc && (g != 2'b00)) begin
        e.src    = g[1];
        e.tag    = g[1] ? req1_tag : req0_tag;
        e.result = g[1] ? m_cmp(req1_op, req1_a, req1_b) : m_cmp(req0_op, req0_a, req0_b);
        sb.push_back(e);
        m_full = 1'b1;
`ifdef CMP_ARB_ROUND_ROBIN_EN
        m_ptr = g[1];
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("rsp_valid", 64'(rsp_valid), 64'(m_full));
    if (m_full && sb.size() > 0) begin
      e = sb[0];
      check("rsp_src", 64'(rsp_src), 64'(e.src));
      check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
      check("rsp_result", 64'(rsp_result), 64'(e.result));
    end else if (was_reset) begin
      check("rst_src", 64'(rsp_src), 64'd0);
      check("rst_tag", 64'(rsp_tag), 64'd0);
      check("rst_result", 64'(rsp_result), 64'd0);
    end
  endtask

  task automatic drive0(input logic v, input op_t op, input logic [`XLEN-1:0] a,
                        input logic [`XLEN-1:0] b, input logic [3:0] tag);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
  endtask

  task automatic drive1(input logic v, input op_t op, input logic [`XLEN-1:0] a,
                        input logic [`XLEN-1:0] b, input logic [3:0] tag);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
  endtask

  initial begin
    logic [1:0] exp_src [4];
    logic       held_src, held_result;
    logic [3:0] held_tag;
`ifdef CMP_ARB_ROUND_ROBIN_EN
    exp_src = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    m_full = 1'b0;
    m_ptr  = 1'b1;
    reset  = 1'b1;
    rsp_ready = 1'b0;
    drive0(1'b0, OpEq, '0, '0, 4'd0);
    drive1(1'b0, OpEq, '0, '0, 4'd0);
    cycle();
    drive0(1'b1, OpEq, 32'd1, 32'd1, 4'd9);
    drive1(1'b1, OpEq, 32'd1, 32'd1, 4'd9);
    cycle();
    reset = 1'b0;
    drive0(1'b0, OpEq, '0, '0, 4'd0);
    drive1(1'b0, OpEq, '0, '0, 4'd0);
    cycle();

    // Lone requester 0, signed less-than of -1 versus 1.
    rsp_ready = 1'b1;
    drive0(1'b1, OpLt, 32'hFFFF_FFFF, 32'd1, 4'd3);
    cycle();
    check("r0_result", 64'(rsp_result), 64'd1);
    check("r0_src", 64'(rsp_src), 64'd0);
    check("r0_tag", 64'(rsp_tag), 64'd3);
    req0_valid = 1'b0;
    cycle();

    // Lone requester 1, unsigned less-than of the same operands.
    drive1(1'b1, OpLtu, 32'hFFFF_FFFF, 32'd1, 4'd5);
    cycle();
    check("r1_result", 64'(rsp_result), 64'd0);
    check("r1_src", 64'(rsp_src), 64'd1);
    check("r1_tag", 64'(rsp_tag), 64'd5);
    req1_valid = 1'b0;
    cycle();

    // Four back-to-back ties.
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, (i % 2 == 0) ? OpGe : OpEq, 32'(i), 32'd2, 4'(i));
      drive1(1'b1, (i % 2 == 0) ? OpGeu : OpNe, 32'hF000_0000, 32'(i), 4'(8 + i));
      cycle();
      check("tie_src", 64'(rsp_src), 64'(exp_src[i]));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();

    // Held result with backpressure, then drain and refill in one cycle.
    rsp_ready = 1'b0;
    drive0(1'b1, OpTrue, 32'd0, 32'd0, 4'd12);
    cycle();
    held_src = rsp_src; held_tag = rsp_tag; held_result = rsp_result;
    drive0(1'b1, OpNe, 32'd4, 32'd4, 4'd1);
    drive1(1'b1, OpLtu, 32'd1, 32'd4, 4'd2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_src", 64'(rsp_src), 64'(held_src));
      check("hold_tag", 64'(rsp_tag), 64'(held_tag));
      check("hold_result", 64'(rsp_result), 64'(held_result));
    end
    check("hold_result_true", 64'(held_result), 64'd1);
    rsp_ready = 1'b1;
    cycle();
    check("refill_valid", 64'(rsp_valid), 64'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cycle();

    // Reset one cycle after an accept discards the held result.
    rsp_ready = 1'b0;
    drive0(1'b1, OpEq, 32'd7, 32'd7, 4'd6);
    cycle();
    req0_valid = 1'b0;
    reset = 1'b1;
    cycle();
    check("r27_valid", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive0(1'b1, OpGeu, 32'd3, 32'd9, 4'd4);
    drive1(1'b1, OpLt, 32'd3, 32'd9, 4'd11);
    #1;
    check("r27_tie_grant", 64'({req1_ready, req0_ready}), 64'd1);
    cycle();

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op    = op_t'(3'($urandom_range(0, 6)));
      req1_op    = op_t'(3'($urandom_range(0, 6)));
      req0_b     = $urandom();
      req1_b     = $urandom();
      req0_a     = ($urandom_range(0, 3) == 0) ? req0_b : $urandom();
      req1_a     = ($urandom_range(0, 3) == 0) ? req1_b : $urandom();
      req0_tag   = 4'($urandom_range(0, 15));
      req1_tag   = 4'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
